multicycle_ctrl: RTL

Main control FSM for the multi-cycle MIPS datapath. It decodes the 6-bit opcode held in the instruction register and sequences the datapath through fetch, decode, execute, memory and write-back. In every state it drives the 3-bit ALU operation code consumed by the downstream ALU controller, along with all mux selects and write strobes. It also handshakes with a variable-latency unified memory, and exposes a retired-instruction counter and an illegal-opcode flag.

---
 rtl/mips_ctrl_pkg.sv | 51 +++++
 rtl/mc_ctrl_outdec.sv | 103 ++++++++++
 rtl/multicycle_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes,
// ALU-controller operation codes, FSM state encoding and mux selects.
package mips_ctrl_pkg;

    // Instruction opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Operation codes understood by the ALU controller
    localparam logic [2:0] ADD   = 3'b100;
    localparam logic [2:0] SUB   = 3'b101;
    localparam logic [2:0] RTYPE = 3'b010;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU B-input select
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_R_EXEC   = 4'd7,
        ST_R_WB     = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_I_EXEC   = 4'd11,
        ST_I_WB     = 4'd12
    } state_t;

    // True for the opcodes this controller knows how to sequence
    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW)  || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)   || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational output decode for the multi-cycle controller. Pure Moore
// decode of the state, except that the FETCH-cycle IR and PC writes wait
// for the memory to return the instruction.
module mc_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic [1:0] pc_source_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       mem_to_reg_o,
    output logic       reg_dst_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o
);

    // Per-state control word; anything not named for a state stays 0
    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        pc_source_o     = PCSRC_ALU;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_dst_o       = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRCB_RT;
        alu_op_o        = 3'b000;
        case (state_i)
            ST_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                alu_op_o    = ADD;
                pc_source_o = PCSRC_ALU;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            ST_DECODE: begin
                alu_src_b_o = SRCB_IMM_SL2;
                alu_op_o    = ADD;
            end
            ST_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ADD;
            end
            ST_MEM_RD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
            end
            ST_R_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_RT;
                alu_op_o    = RTYPE;
            end
            ST_R_WB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
                alu_op_o    = RTYPE;
            end
            ST_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_src_b_o     = SRCB_RT;
                alu_op_o        = SUB;
                pc_write_cond_o = 1'b1;
                pc_source_o     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                pc_write_o  = 1'b1;
                pc_source_o = PCSRC_JUMP;
            end
            ST_I_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ADD;
            end
            ST_I_WB: begin
                reg_write_o = 1'b1;
                alu_op_o    = ADD;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath: state register,
// opcode-driven next-state logic and retired-instruction counter. Control
// outputs are decoded from the state by mc_ctrl_outdec.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       opcode_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             pc_write_cond_o,
    output logic [1:0]       pc_source_o,
    output logic             iord_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             ir_write_o,
    output logic             mem_to_reg_o,
    output logic             reg_dst_o,
    output logic             reg_write_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [2:0]       alu_op_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    state_t           r_state;
    state_t           w_next;
    logic             r_run;
    logic [CNT_W-1:0] r_cnt;
    logic             w_retire;

    // Next-state selection; w_retire marks the last cycle of a legal instruction
    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            ST_IDLE:     if (r_run) w_next = ST_FETCH;
            ST_FETCH:    if (mem_ready_i) w_next = ST_DECODE;
            ST_DECODE: begin
                case (opcode_i)
                    OP_LW, OP_SW: w_next = ST_MEM_ADDR;
                    OP_RTYPE:     w_next = ST_R_EXEC;
                    OP_BEQ:       w_next = ST_BRANCH;
                    OP_J:         w_next = ST_JUMP;
                    OP_ADDI:      w_next = ST_I_EXEC;
                    default:      w_next = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR: w_next = (opcode_i == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   if (mem_ready_i) w_next = ST_MEM_WB;
            ST_MEM_WB: begin
                w_next   = ST_FETCH;
                w_retire = 1'b1;
            end
            ST_MEM_WR: begin
                if (mem_ready_i) begin
                    w_next   = ST_FETCH;
                    w_retire = 1'b1;
                end
            end
            ST_R_EXEC:   w_next = ST_R_WB;
            ST_R_WB: begin
                w_next   = ST_FETCH;
                w_retire = 1'b1;
            end
            ST_BRANCH: begin
                w_next   = ST_FETCH;
                w_retire = 1'b1;
            end
            ST_JUMP: begin
                w_next   = ST_FETCH;
                w_retire = 1'b1;
            end
            ST_I_EXEC:   w_next = ST_I_WB;
            ST_I_WB: begin
                w_next   = ST_FETCH;
                w_retire = 1'b1;
            end
            default:     w_next = ST_IDLE;
        endcase
    end

    // State, reset-release flag and retire counter; r_run holds IDLE for one
    // extra edge so the first FETCH lands on the second edge after release
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_run   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_next;
            if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign illegal_o   = (r_state == ST_DECODE) && !is_legal(opcode_i);
    assign instr_cnt_o = r_cnt;

    mc_ctrl_outdec u_outdec (
        .state_i         (r_state),
        .mem_ready_i     (mem_ready_i),
        .pc_write_o      (pc_write_o),
        .pc_write_cond_o (pc_write_cond_o),
        .pc_source_o     (pc_source_o),
        .iord_o          (iord_o),
        .mem_read_o      (mem_read_o),
        .mem_write_o     (mem_write_o),
        .ir_write_o      (ir_write_o),
        .mem_to_reg_o    (mem_to_reg_o),
        .reg_dst_o       (reg_dst_o),
        .reg_write_o     (reg_write_o),
        .alu_src_a_o     (alu_src_a_o),
        .alu_src_b_o     (alu_src_b_o),
        .alu_op_o        (alu_op_o)
    );

endmodule
